corefifo_rd_ctrl: RTL and testbench

//  Read-domain controller of the async FIFO. Synchronises the write-side Gray pointer and

---
 rtl/corefifo_rd_ctrl_pkg.sv | 11 +
 rtl/corefifo_rd_ctrl_graytobin.sv | 18 +
 rtl/corefifo_rd_ctrl.sv | 157 +++++++++++++++
 tb/tb_corefifo_rd_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/corefifo_rd_ctrl_pkg.sv
// Shared types for the async FIFO read-domain controller.
// FWFT state encodings are fixed so the write side and debug tools can decode them.
package corefifo_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } rd_state_t;

endpackage

// File: rtl/corefifo_rd_ctrl_graytobin.sv
// Gray-to-binary converter for FIFO pointers.
// Each binary bit is the XOR of all Gray bits at or above its position.
module tx_fifo_tx_fifo_0_corefifo_grayToBinConv #(
  parameter int ADDRWIDTH = 3
) (
  input  logic [ADDRWIDTH:0] gray,
  output logic [ADDRWIDTH:0] bin
);

  // Prefix XOR from the MSB down.
  always_comb begin
    bin = gray;
    for (int i = 0; i <= ADDRWIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/corefifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: write-pointer sync, read pointer,
// RAM read sequencing, empty/almost-empty/fill count and underflow, std or FWFT.
module corefifo_rd_ctrl
  import corefifo_rd_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1,
  parameter int FWFT        = 0
) (
  input  logic                 RCLOCK,
  input  logic                 RRESET_N,
  input  logic [ADDRWIDTH:0]   wptr_gray_in,
  input  logic                 re,
  output logic                 ram_re,
  output logic [ADDRWIDTH-1:0] ram_raddr,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic                 dvld,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rd_cnt,
  output logic                 underflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] ONE  = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0] ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [SYNC_STAGES-1:0][PW-1:0] r_wsync;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] r_rptr_bin;
  logic [PW-1:0] r_rptr_gray;
  logic [PW-1:0] w_rptr_next;
  logic [PW-1:0] w_memcnt;
  logic [PW-1:0] w_rd_cnt;
  logic          w_mem_empty;
  logic          w_ram_re;
  logic          w_empty;
  logic          r_dvld;
  logic          r_underflow;
  rd_state_t     r_state;

  // Write-pointer synchroniser; only the last stage feeds any logic.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      r_wsync <= '0;
    end else begin
      r_wsync <= {r_wsync[SYNC_STAGES-2:0], wptr_gray_in};
    end
  end

  tx_fifo_tx_fifo_0_corefifo_grayToBinConv #(
    .ADDRWIDTH(ADDRWIDTH)
  ) u_g2b (
    .gray(r_wsync[SYNC_STAGES-1]),
    .bin (w_wbin)
  );

  assign w_memcnt    = w_wbin - r_rptr_bin;
  assign w_mem_empty = (w_memcnt == ZERO);
  assign w_rptr_next = r_rptr_bin + ONE;

  // RAM read enable: FWFT prefetches the head word on its own.
  always_comb begin
    w_ram_re = 1'b0;
    if (FWFT == 0) begin
      w_ram_re = re & ~w_mem_empty;
    end else begin
      case (r_state)
        S_EMPTY: w_ram_re = ~w_mem_empty;
        S_VALID: w_ram_re = re & ~w_mem_empty;
        default: w_ram_re = 1'b0;
      endcase
    end
  end

  // Flags and count decoded from registers only.
  always_comb begin
    w_empty  = w_mem_empty;
    w_rd_cnt = w_memcnt;
    if (FWFT != 0) begin
      w_empty  = ~r_dvld;
      w_rd_cnt = w_memcnt + ((r_state != S_EMPTY) ? ONE : ZERO);
    end else begin
      w_empty  = w_mem_empty;
      w_rd_cnt = w_memcnt;
    end
  end

  // Read pointer, binary and Gray, advanced only by an actual RAM read.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      r_rptr_bin  <= ZERO;
      r_rptr_gray <= ZERO;
    end else if (w_ram_re) begin
      r_rptr_bin  <= w_rptr_next;
      r_rptr_gray <= w_rptr_next ^ (w_rptr_next >> 1);
    end else begin
      r_rptr_bin  <= r_rptr_bin;
      r_rptr_gray <= r_rptr_gray;
    end
  end

  // Data-valid sequencing, FWFT state machine and underflow pulse.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      r_state     <= S_EMPTY;
      r_dvld      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= re & w_empty;
      if (FWFT == 0) begin
        r_state <= S_EMPTY;
        r_dvld  <= w_ram_re;
      end else begin
        case (r_state)
          S_EMPTY: begin
            r_dvld <= 1'b0;
            if (!w_mem_empty) begin
              r_state <= S_FETCH;
            end else begin
              r_state <= S_EMPTY;
            end
          end
          S_FETCH: begin
            r_dvld  <= 1'b1;
            r_state <= S_VALID;
          end
          S_VALID: begin
            if (re && w_mem_empty) begin
              r_dvld  <= 1'b0;
              r_state <= S_EMPTY;
            end else begin
              r_dvld  <= 1'b1;
              r_state <= S_VALID;
            end
          end
          default: begin
            r_dvld  <= 1'b0;
            r_state <= S_EMPTY;
          end
        endcase
      end
    end
  end

  assign ram_re    = w_ram_re;
  assign ram_raddr = r_rptr_bin[ADDRWIDTH-1:0];
  assign rptr_gray = r_rptr_gray;
  assign dvld      = r_dvld;
  assign empty     = w_empty;
  assign aempty    = (w_rd_cnt <= AE_T);
  assign rd_cnt    = w_rd_cnt;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Directed bench for corefifo_rd_ctrl: standard, wrap, underflow, FWFT, almost-empty, reset.
module tb_corefifo_rd_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Standard-mode instance
  logic [3:0] wg_s = 4'd0;
  logic       re_s = 1'b0;
  logic       ram_re_s, dvld_s, empty_s, aempty_s, uf_s;
  logic [2:0] raddr_s;
  logic [3:0] rgray_s, cnt_s;

  // FWFT instance
  logic [3:0] wg_f = 4'd0;
  logic       re_f = 1'b0;
  logic       ram_re_f, dvld_f, empty_f, aempty_f, uf_f;
  logic [2:0] raddr_f;
  logic [3:0] rgray_f, cnt_f;

  // Standard-mode instance, AE_THRESH=2
  logic [3:0] wg_a = 4'd0;
  logic       re_a = 1'b0;
  logic       ram_re_a, dvld_a, empty_a, aempty_a, uf_a;
  logic [2:0] raddr_a;
  logic [3:0] rgray_a, cnt_a;

  corefifo_rd_ctrl #(.ADDRWIDTH(3), .SYNC_STAGES(2), .AE_THRESH(1), .FWFT(0)) u_std (
    .RCLOCK(clk), .RRESET_N(rst_n), .wptr_gray_in(wg_s), .re(re_s),
    .ram_re(ram_re_s), .ram_raddr(raddr_s), .rptr_gray(rgray_s), .dvld(dvld_s),
    .empty(empty_s), .aempty(aempty_s), .rd_cnt(cnt_s), .underflow(uf_s));

  corefifo_rd_ctrl #(.ADDRWIDTH(3), .SYNC_STAGES(2), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .RCLOCK(clk), .RRESET_N(rst_n), .wptr_gray_in(wg_f), .re(re_f),
    .ram_re(ram_re_f), .ram_raddr(raddr_f), .rptr_gray(rgray_f), .dvld(dvld_f),
    .empty(empty_f), .aempty(aempty_f), .rd_cnt(cnt_f), .underflow(uf_f));

  corefifo_rd_ctrl #(.ADDRWIDTH(3), .SYNC_STAGES(2), .AE_THRESH(2), .FWFT(0)) u_ae (
    .RCLOCK(clk), .RRESET_N(rst_n), .wptr_gray_in(wg_a), .re(re_a),
    .ram_re(ram_re_a), .ram_raddr(raddr_a), .rptr_gray(rgray_a), .dvld(dvld_a),
    .empty(empty_a), .aempty(aempty_a), .rd_cnt(cnt_a), .underflow(uf_a));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Power-up reset values
    #2;
    chk("rst_empty", empty_s, 1);
    chk("rst_aempty", aempty_s, 1);
    chk("rst_cnt", cnt_s, 0);
    chk("rst_ramre", ram_re_s, 0);
    chk("rst_f_empty", empty_f, 1);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset mid-operation: build rd_cnt=5, dvld=1, then drop reset between edges
    wg_s = 4'b0101;
    tick();
    tick();
    chk("pre_cnt6", cnt_s, 6);
    re_s = 1'b1;
    tick();
    re_s = 1'b0;
    chk("mid_dvld", dvld_s, 1);
    chk("mid_cnt5", cnt_s, 5);
    rst_n = 1'b0;
    wg_s = 4'b0000;
    #1;
    chk("async_empty", empty_s, 1);
    chk("async_aempty", aempty_s, 1);
    chk("async_cnt", cnt_s, 0);
    chk("async_dvld", dvld_s, 0);
    chk("async_rgray", rgray_s, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Standard read of one word
    wg_s = 4'b0001;
    tick();
    chk("std_sync1_empty", empty_s, 1);
    tick();
    chk("std_empty", empty_s, 0);
    chk("std_cnt", cnt_s, 1);
    re_s = 1'b1;
    #1;
    chk("std_ramre", ram_re_s, 1);
    chk("std_raddr", raddr_s, 0);
    tick();
    re_s = 1'b0;
    chk("std_rgray", rgray_s, 4'b0001);
    chk("std_dvld", dvld_s, 1);
    chk("std_empty_after", empty_s, 1);
    tick();
    chk("std_dvld_drop", dvld_s, 0);

    // Underflow: re while empty
    re_s = 1'b1;
    #1;
    chk("uf_ramre", ram_re_s, 0);
    tick();
    re_s = 1'b0;
    chk("uf_pulse", uf_s, 1);
    chk("uf_rgray", rgray_s, 4'b0001);
    tick();
    chk("uf_clear", uf_s, 0);

    // Wrap: rptr_bin 1 -> 7 with wbin = 9, then read across the address wrap
    wg_s = 4'b1101;
    tick();
    tick();
    chk("wrap_cnt8", cnt_s, 8);
    chk("wrap_aempty0", aempty_s, 0);
    re_s = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_raddr7", raddr_s, 3'b111);
    chk("wrap_cnt2", cnt_s, 2);
    chk("wrap_ramre", ram_re_s, 1);
    tick();
    re_s = 1'b0;
    chk("wrap_rgray", rgray_s, 4'b1100);
    chk("wrap_raddr0", raddr_s, 3'b000);
    chk("wrap_cnt1", cnt_s, 1);
    chk("wrap_aempty1", aempty_s, 1);

    // FWFT: two words, automatic prefetch, then back-to-back reads
    wg_f = 4'b0011;
    tick();
    chk("fw_e1_ramre", ram_re_f, 0);
    tick();
    chk("fw_e2_ramre", ram_re_f, 1);
    chk("fw_e2_empty", empty_f, 1);
    tick();
    chk("fw_e3_ramre", ram_re_f, 0);
    chk("fw_e3_dvld", dvld_f, 0);
    chk("fw_e3_cnt", cnt_f, 2);
    tick();
    chk("fw_e4_dvld", dvld_f, 1);
    chk("fw_e4_cnt", cnt_f, 2);
    chk("fw_e4_empty", empty_f, 0);
    chk("fw_e4_ramre", ram_re_f, 0);
    tick();
    chk("fw_hold_dvld", dvld_f, 1);
    chk("fw_hold_raddr", raddr_f, 3'b001);
    re_f = 1'b1;
    #1;
    chk("fw_rd1_ramre", ram_re_f, 1);
    tick();
    chk("fw_rd1_dvld", dvld_f, 1);
    chk("fw_rd1_cnt", cnt_f, 1);
    chk("fw_rd1_uf", uf_f, 0);
    chk("fw_rd2_ramre", ram_re_f, 0);
    tick();
    re_f = 1'b0;
    chk("fw_end_dvld", dvld_f, 0);
    chk("fw_end_empty", empty_f, 1);
    chk("fw_end_cnt", cnt_f, 0);
    chk("fw_end_uf", uf_f, 0);
    chk("fw_end_rgray", rgray_f, 4'b0011);
    re_f = 1'b1;
    tick();
    re_f = 1'b0;
    chk("fw_uf", uf_f, 1);
    chk("fw_uf_rgray", rgray_f, 4'b0011);

    // Almost-empty with AE_THRESH=2
    wg_a = 4'b0010;
    tick();
    tick();
    chk("ae_cnt3", cnt_a, 3);
    chk("ae_low", aempty_a, 0);
    re_a = 1'b1;
    tick();
    re_a = 1'b0;
    chk("ae_cnt2", cnt_a, 2);
    chk("ae_rise", aempty_a, 1);
    wg_a = 4'b0110;
    tick();
    chk("ae_sync1", aempty_a, 1);
    tick();
    chk("ae_cnt3b", cnt_a, 3);
    chk("ae_fall", aempty_a, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
